// File: rtl/lerp2_tile_walker_if.sv
// Bundles the walker's job intake, lerp2 operand/handshake and output stream.
// "master" is the walker side and "slave" is the surrounding system.
interface lerp2_tile_walker_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 12
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic signed [WIDTH-1:0] cfg_p0;
  logic signed [WIDTH-1:0] cfg_p1;
  logic signed [WIDTH-1:0] cfg_p2;
  logic signed [WIDTH-1:0] cfg_p3;
  logic [CW-1:0]           cfg_w;
  logic [CW-1:0]           cfg_h;

  logic [WIDTH-1:0]        l_p0;
  logic [WIDTH-1:0]        l_p1;
  logic [WIDTH-1:0]        l_p2;
  logic [WIDTH-1:0]        l_p3;
  logic [WIDTH-1:0]        l_x;
  logic [WIDTH-1:0]        l_y;
  logic [WIDTH-1:0]        l_X;
  logic [WIDTH-1:0]        l_Y;
  logic                    l_start;
  logic                    l_done;
  logic [WIDTH-1:0]        l_val;

  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_val;
  logic [CW-1:0]           out_x;
  logic [CW-1:0]           out_y;
  logic                    out_last;
  logic                    job_done;

  modport master (
    input  cfg_valid, cfg_p0, cfg_p1, cfg_p2, cfg_p3, cfg_w, cfg_h,
    output cfg_ready,
    output l_p0, l_p1, l_p2, l_p3, l_x, l_y, l_X, l_Y, l_start,
    input  l_done, l_val,
    output out_valid, out_val, out_x, out_y, out_last, job_done,
    input  out_ready
  );

  modport slave (
    output cfg_valid, cfg_p0, cfg_p1, cfg_p2, cfg_p3, cfg_w, cfg_h,
    input  cfg_ready,
    input  l_p0, l_p1, l_p2, l_p3, l_x, l_y, l_X, l_Y, l_start,
    output l_done, l_val,
    input  out_valid, out_val, out_x, out_y, out_last, job_done,
    output out_ready
  );
endinterface

// File: rtl/lerp2_tile_walker.sv
// Raster-order tile sequencer in front of lerp2: one evaluation outstanding at a
// time, each result presented on a valid/ready stream with coordinates and last.
module lerp2_tile_walker #(
  parameter int WIDTH = 32,
  parameter int CW    = 12
) (
  input  logic                clock,
  input  logic                reset,
  lerp2_tile_walker_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t           state_reg, state_next;
  logic             cfg_ready_reg, cfg_ready_next;
  logic             l_start_reg, l_start_next;
  logic             out_valid_reg, out_valid_next;
  logic             job_done_reg, job_done_next;

  logic [WIDTH-1:0] corner_in  [4];
  logic [WIDTH-1:0] corner_reg [4];
  logic [CW-1:0]    w_reg, h_reg;
  logic [CW-1:0]    x_cnt_reg, y_cnt_reg;
  logic [WIDTH-1:0] out_val_reg;
  logic [CW-1:0]    out_x_reg, out_y_reg;
  logic             out_last_reg;

  logic             accept, degen, fire, x_end, y_end;

  // Span of one axis; a single-sample axis reports 1 so lerp2 never divides by zero.
  function automatic logic [WIDTH-1:0] span(input logic [CW-1:0] n);
    logic [CW-1:0] s;
    if (n == '0)
      s = '0;
    else if (n == CW'(1))
      s = CW'(1);
    else
      s = n - CW'(1);
    return WIDTH'(s);
  endfunction

  assign accept = (state_reg == IDLE) && cfg_ready_reg && bus.cfg_valid;
  assign degen  = (bus.cfg_w == '0) || (bus.cfg_h == '0);
  assign fire   = (state_reg == OUT) && out_valid_reg && bus.out_ready;
  assign x_end  = (x_cnt_reg == w_reg - CW'(1));
  assign y_end  = (y_cnt_reg == h_reg - CW'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cfg_ready_reg <= 1'b0;
      l_start_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      job_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cfg_ready_reg <= cfg_ready_next;
      l_start_reg   <= l_start_next;
      out_valid_reg <= out_valid_next;
      job_done_reg  <= job_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept && !degen) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (bus.l_done) state_next = OUT;
      OUT:   if (fire) state_next = out_last_reg ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of what the next state implies.
  always_comb begin
    cfg_ready_next = (state_next == IDLE);
    l_start_next   = (state_next == ISSUE);
    out_valid_next = (state_next == OUT);
    job_done_next  = (accept && degen) || (fire && out_last_reg);
  end

  assign corner_in[0] = bus.cfg_p0;
  assign corner_in[1] = bus.cfg_p1;
  assign corner_in[2] = bus.cfg_p2;
  assign corner_in[3] = bus.cfg_p3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_corner
    always_ff @(posedge clock) begin
      if (!reset)
        corner_reg[gi] <= '0;
      else if (accept)
        corner_reg[gi] <= corner_in[gi];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_reg        <= '0;
      h_reg        <= '0;
      x_cnt_reg    <= '0;
      y_cnt_reg    <= '0;
      out_val_reg  <= '0;
      out_x_reg    <= '0;
      out_y_reg    <= '0;
      out_last_reg <= 1'b0;
    end else begin
      if (accept) begin
        w_reg     <= bus.cfg_w;
        h_reg     <= bus.cfg_h;
        x_cnt_reg <= '0;
        y_cnt_reg <= '0;
      end
      if (state_reg == WAIT && bus.l_done) begin
        out_val_reg  <= bus.l_val;
        out_x_reg    <= x_cnt_reg;
        out_y_reg    <= y_cnt_reg;
        out_last_reg <= x_end && y_end;
      end
      if (fire && !out_last_reg) begin
        if (x_end) begin
          x_cnt_reg <= '0;
          y_cnt_reg <= y_cnt_reg + CW'(1);
        end else begin
          x_cnt_reg <= x_cnt_reg + CW'(1);
        end
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.l_p0      = corner_reg[0];
  assign bus.l_p1      = corner_reg[1];
  assign bus.l_p2      = corner_reg[2];
  assign bus.l_p3      = corner_reg[3];
  assign bus.l_x       = WIDTH'(x_cnt_reg);
  assign bus.l_y       = WIDTH'(y_cnt_reg);
  assign bus.l_X       = span(w_reg);
  assign bus.l_Y       = span(h_reg);
  assign bus.l_start   = l_start_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_val   = out_val_reg;
  assign bus.out_x     = out_x_reg;
  assign bus.out_y     = out_y_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.job_done  = job_done_reg;
endmodule

// File: tb/tb_lerp2_tile_walker.sv
// Bench for lerp2_tile_walker: behavioural lerp2 responder plus a scoreboard of
// expected samples filled when each job is offered and drained on each handshake.
module tb_lerp2_tile_walker;
  localparam int WIDTH = 32;
  localparam int CW    = 12;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lerp2_tile_walker_if #(.WIDTH(WIDTH), .CW(CW)) bus ();
  lerp2_tile_walker #(.WIDTH(WIDTH), .CW(CW)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [WIDTH-1:0] val;
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic             last;
  } sample_t;

  sample_t    exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_start = 0;
  int         n_out = 0;
  int         n_jobdone = 0;
  int         exp_jobs = 0;
  int         stall_at = -1;
  int         lat_force = 0;
  bit         rand_ready = 1'b0;
  logic [WIDTH-1:0] last_X = '0;
  logic [WIDTH-1:0] last_Y = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference bilinear interpolation on plain integer positions.
  function automatic longint lerp_f(input longint p0, p1, p2, p3, x, y, sx, sy);
    longint top, bot;
    if (sx <= 0 || sy <= 0) return 64'hBAD0_BAD0;
    top = p0 + ((p1 - p0) * x) / sx;
    bot = p2 + ((p3 - p2) * x) / sx;
    return top + ((bot - top) * y) / sy;
  endfunction

  // lerp2 stand-in: latency-delayed done, checking operand stability meanwhile.
  initial begin
    logic [WIDTH-1:0] c0, c1, c2, c3, cx, cy, cX, cY;
    int  lat;
    bit  aborted;
    bus.l_done = 1'b0;
    bus.l_val  = '0;
    forever begin
      @(negedge clock);
      if (reset && bus.l_start) begin
        n_start++;
        c0 = bus.l_p0; c1 = bus.l_p1; c2 = bus.l_p2; c3 = bus.l_p3;
        cx = bus.l_x;  cy = bus.l_y;  cX = bus.l_X;  cY = bus.l_Y;
        last_X = cX;
        last_Y = cY;
        lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clock);
          if (!reset) aborted = 1'b1;
          if (!aborted) begin
            if (k == 0) check_eq("l_start_one_cycle", bus.l_start, 1'b0);
            check_eq("l_ops_stable",
                     {bus.l_p0, bus.l_p1, bus.l_p2, bus.l_p3, bus.l_x, bus.l_y, bus.l_X, bus.l_Y}
                       == {c0, c1, c2, c3, cx, cy, cX, cY}, 1'b1);
          end
        end
        bus.l_val  = WIDTH'(lerp_f(longint'($signed(c0)), longint'($signed(c1)),
                                   longint'($signed(c2)), longint'($signed(c3)),
                                   longint'(cx), longint'(cy), longint'(cX), longint'(cY)));
        bus.l_done = 1'b1;
        @(negedge clock);
        bus.l_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.job_done) n_jobdone++;
    end
  end

  // Output consumer: drives out_ready, optionally stalls, and drains the scoreboard.
  initial begin
    sample_t s;
    logic [WIDTH-1:0] hold_val;
    logic [CW-1:0]    hold_x;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && n_out == stall_at) begin
          bus.out_ready = 1'b0;
          hold_val = bus.out_val;
          hold_x   = bus.out_x;
          repeat (5) begin
            @(negedge clock);
            check_eq("stall_valid", bus.out_valid, 1'b1);
            check_eq("stall_val", bus.out_val, hold_val);
            check_eq("stall_x", bus.out_x, hold_x);
            check_eq("stall_no_start", bus.l_start, 1'b0);
          end
          bus.out_ready = 1'b1;
          stall_at = -1;
        end
        if (bus.out_valid && bus.out_ready) begin
          check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            $display("sample (%0d,%0d) val=0x%0h last=%0b", bus.out_x, bus.out_y, bus.out_val, bus.out_last);
            check_eq("out_val", bus.out_val, s.val);
            check_eq("out_x", bus.out_x, s.x);
            check_eq("out_y", bus.out_y, s.y);
            check_eq("out_last", bus.out_last, s.last);
          end
          n_out++;
        end
      end
    end
  end

  task automatic send_job(input logic [WIDTH-1:0] p0, p1, p2, p3, input int w, h, input bit b2b);
    int guard;
    sample_t s;
    longint sx, sy;
    @(negedge clock);
    bus.cfg_p0 = p0; bus.cfg_p1 = p1; bus.cfg_p2 = p2; bus.cfg_p3 = p3;
    bus.cfg_w = w[CW-1:0];
    bus.cfg_h = h[CW-1:0];
    bus.cfg_valid = 1'b1;
    guard = 0;
    while (!bus.cfg_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check_eq("cfg_accept_bound", guard < 2000, 1'b1);
    if (b2b) check_eq("b2b_job_done_with_accept", bus.job_done, 1'b1);
    sx = (w == 1) ? 1 : w - 1;
    sy = (h == 1) ? 1 : h - 1;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        s.val  = WIDTH'(lerp_f(longint'($signed(p0)), longint'($signed(p1)),
                               longint'($signed(p2)), longint'($signed(p3)),
                               longint'(xx), longint'(yy), sx, sy));
        s.x    = xx[CW-1:0];
        s.y    = yy[CW-1:0];
        s.last = (xx == w - 1) && (yy == h - 1);
        exp_q.push_back(s);
      end
    end
    exp_jobs++;
    $display("job p0=0x%0h p1=0x%0h p2=0x%0h p3=0x%0h w=%0d h=%0d", p0, p1, p2, p3, w, h);
    @(posedge clock);
  endtask

  task automatic drop_valid();
    @(negedge clock);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !bus.cfg_ready || bus.out_valid) && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    repeat (2) @(negedge clock);
    check_eq({tag, "_drain_bound"}, guard < 5000, 1'b1);
    check_eq({tag, "_job_done_count"}, n_jobdone, exp_jobs);
    check_eq({tag, "_starts_vs_outputs"}, n_start, n_out);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_cfg_ready"}, bus.cfg_ready, 1'b0);
    check_eq({tag, "_l_start"}, bus.l_start, 1'b0);
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_out_last"}, bus.out_last, 1'b0);
    check_eq({tag, "_job_done"}, bus.job_done, 1'b0);
    check_eq({tag, "_out_val"}, bus.out_val, 0);
    check_eq({tag, "_out_xy"}, {bus.out_x, bus.out_y}, 0);
    check_eq({tag, "_l_x"}, bus.l_x, 0);
    check_eq({tag, "_l_p1"}, bus.l_p1, 0);
  endtask

  initial begin
    int base, guard;
    bus.cfg_valid = 1'b0;
    bus.cfg_p0 = '0; bus.cfg_p1 = '0; bus.cfg_p2 = '0; bus.cfg_p3 = '0;
    bus.cfg_w = '0; bus.cfg_h = '0;

    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    check_eq("reset_release_cfg_ready", bus.cfg_ready, 1'b1);

    // Basic 3x2 tile.
    send_job(32'h0, 32'h40000, 32'h0, 32'h40000, 3, 2, 1'b0);
    drop_valid();
    wait_idle("basic");
    check_eq("basic_l_X", last_X, 2);
    check_eq("basic_l_Y", last_Y, 1);

    // Same tile with the second sample held off for five cycles.
    stall_at = n_out + 1;
    send_job(32'h0, 32'h40000, 32'h0, 32'h40000, 3, 2, 1'b0);
    drop_valid();
    wait_idle("backpressure");

    // Zero-size jobs finish without issuing anything.
    base = n_start;
    send_job(32'h11, 32'h22, 32'h33, 32'h44, 0, 4, 1'b0);
    @(negedge clock);
    check_eq("w0_job_done_next", bus.job_done, 1'b1);
    check_eq("w0_no_out_valid", bus.out_valid, 1'b0);
    bus.cfg_valid = 1'b0;
    @(negedge clock);
    check_eq("w0_job_done_single", bus.job_done, 1'b0);
    send_job(32'h11, 32'h22, 32'h33, 32'h44, 3, 0, 1'b0);
    drop_valid();
    wait_idle("degenerate");
    check_eq("degenerate_no_start", n_start, base);

    // Single-sample tile.
    send_job(32'h7000, 32'h1234, 32'hFFFF_F000, 32'h55, 1, 1, 1'b0);
    drop_valid();
    wait_idle("one_by_one");
    check_eq("one_l_X", last_X, 1);
    check_eq("one_l_Y", last_Y, 1);

    // Reset while waiting on sample (1,0); its late done must be ignored.
    lat_force = 8;
    base = n_start;
    send_job(32'h0, 32'h40000, 32'h0, 32'h40000, 3, 2, 1'b0);
    drop_valid();
    guard = 0;
    while (n_start < base + 2 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check_eq("rst_reach_second_sample", guard < 200, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_zero_outputs("midjob_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midjob_release_cfg_ready", bus.cfg_ready, 1'b1);
    repeat (12) begin
      @(negedge clock);
      check_eq("late_done_no_output", bus.out_valid, 1'b0);
    end
    lat_force = 0;
    n_start = 0; n_out = 0; n_jobdone = 0; exp_jobs = 0;

    send_job(32'h0, 32'h40000, 32'h0, 32'h40000, 3, 2, 1'b0);
    drop_valid();
    wait_idle("after_reset");

    // Back-to-back jobs with cfg_valid held high.
    send_job(32'h0, 32'h40000, 32'h0, 32'h40000, 3, 2, 1'b0);
    send_job(32'h100, 32'h300, 32'hFFFF_FE00, 32'h500, 2, 2, 1'b1);
    drop_valid();
    wait_idle("back_to_back");

    // Random corners and sizes under random backpressure.
    rand_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      send_job(WIDTH'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000,
               WIDTH'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000,
               WIDTH'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000,
               WIDTH'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000,
               int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 1'b0);
      drop_valid();
      wait_idle("random");
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lerp2_tile_walker.md
Name: lerp2_tile_walker

Overview:
- Sequencer directly upstream of lerp2: accepts one tile job (four corner values plus integer tile width/height), then walks every (x,y) sample in raster order.
- For each sample, starts one lerp2 evaluation, waits for its done, and captures val.
- Emits each result on a valid/ready output stream with coordinates and a last flag.
- Turns lerp2's start/done pulse interface into a flow-controlled pixel stream for the voxel shading path.

Parameters:
- WIDTH, 32, data width of corner values, lerp2 operands and output value.
- CW, 12, width of tile dimension and coordinate counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  walker can accept a job.
- cfg_p0, cfg_p1, cfg_p2, cfg_p3  in  WIDTH each  corner values (signed); p0 at (0,0), p1 at (w-1,0), p2 at (0,h-1), p3 at (w-1,h-1).
- cfg_w, cfg_h  in  CW each  tile width/height in samples (unsigned).
- l_p0, l_p1, l_p2, l_p3  out  WIDTH each  latched corners to lerp2.
- l_x, l_y, l_X, l_Y  out  WIDTH each  sample position and span to lerp2.
- l_start  out  1  one-cycle start pulse to lerp2.
- l_done  in  1  lerp2 done.
- l_val  in  WIDTH  lerp2 result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_val  out  WIDTH  interpolated value.
- out_x, out_y  out  CW each  sample coordinate.
- out_last  out  1  final sample of the job.
- job_done  out  1  one-cycle pulse when a job finishes.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - cfg_ready, l_start, out_valid, out_last and job_done go to 0.
  - Counters, out_val, out_x and out_y clear to 0.
  - Any job in flight is abandoned. A lerp2 done arriving later is ignored because l_done is only sampled in WAIT.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch p0..p3, w and h, and clear x_cnt/y_cnt.
  - If w==0 or h==0: pulse job_done next cycle, emit no samples, stay in IDLE.
  - Otherwise go to ISSUE.
  - cfg_ready=0 in every other state.
- ISSUE: l_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold all l_* operands stable.
  - On l_done=1: register l_val into out_val and x_cnt/y_cnt into out_x/out_y.
  - Set out_last = (x_cnt==w-1 && y_cnt==h-1), then go to OUT.
  - No timeout.
- OUT:
  - out_valid=1; out_val, out_x, out_y and out_last are held stable until the handshake.
  - On out_valid && out_ready with the last sample: pulse job_done, go to IDLE.
  - On out_valid && out_ready otherwise: if x_cnt==w-1 then x_cnt=0 and y_cnt++, else x_cnt++; go to ISSUE.
  - No state change while out_ready=0.
- Operand encoding (plain integers, not shifted by FBITS; this keeps (p1-p0)*x within WIDTH and the ratio scale-free):
  - l_x = zero-extended x_cnt; l_y = zero-extended y_cnt.
  - l_X = w-1, or 1 when w==1. l_Y = h-1, or 1 when h==1. The forced 1 prevents divide-by-zero inside lerp2.
  - l_p0..l_p3 = latched corners.
- Throughput: one sample per (2 + lerp2 latency + output stall) cycles. There is no overlap and only one lerp2 evaluation is outstanding at a time.
- Simultaneous events:
  - job_done and cfg_ready are both high in the first IDLE cycle after completion; a new job may be accepted in that cycle.
  - cfg_valid is ignored outside IDLE.

Test Plan:
- Basic tile: FBITS=16, p0=0, p1=0x40000, p2=0, p3=0x40000, w=3, h=2, out_ready=1 -> 6 outputs in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) with vals 0, 0x20000, 0x40000, 0, 0x20000, 0x40000; l_X=2, l_Y=1; out_last only on (2,1); one job_done pulse.
- Backpressure: same job, out_ready low for 5 cycles on the second sample -> out_valid stays 1, out_val=0x20000 and out_x=1 stay stable, l_start does not pulse until after the accept; output sequence is unchanged.
- Degenerate sizes: w=0, h=4 -> no l_start, no out_valid, job_done one cycle after accept. w=1, h=1, p0=0x7000 -> l_X=1, l_Y=1, single output val=0x7000 with out_last=1.
- Reset mid-job: assert reset during WAIT of sample (1,0) -> next cycle all outputs 0 and cfg_ready=0, then cfg_ready=1 once reset releases. A late l_done pulse produces no output. A fresh job runs correctly.
- Back-to-back jobs: cfg_valid held high with a second job queued -> second job accepted in the cycle job_done pulses; coordinates restart at (0,0); corners come from the second job.
- Protocol check: for every sample, exactly one l_start per output, and l_* operands never change between l_start and l_done.
